apb_uart_ctrl: RTL and testbench

//  APB master that sequences the UART register slave on behalf of a byte-stream host:

---
 rtl/apb_uart_pkg.sv | 23 ++
 rtl/apb_uart_txq.sv | 53 +++++
 rtl/apb_uart_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_apb_uart_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared encodings for the APB UART controller: FSM states, UART register map and
// the arbiter's request-select codes.
package apb_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_BAUD = 2'd1,
      SEL_TX   = 2'd2,
      SEL_RX   = 2'd3
   } req_sel_e;

   localparam logic [1:0] ADDR_BAUD = 2'd0;
   localparam logic [1:0] ADDR_STAT = 2'd1;
   localparam logic [1:0] ADDR_TXD  = 2'd2;
   localparam logic [1:0] ADDR_RXD  = 2'd3;

endpackage

// File: rtl/apb_uart_txq.sv
// Synchronous TX byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module apb_uart_txq #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge pclk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/apb_uart_ctrl.sv
// APB master sequencing a UART slave: baud programming, TX queue drain, RX byte reads.
// Optional APB_TIMEOUT_EN adds an ACCESS-phase timeout with a sticky err flag.
module apb_uart_ctrl
   import apb_uart_pkg::*;
#(
   parameter int                  BITWIDTH  = 8,
   parameter int                  TXQ_DEPTH = 4,
   parameter logic [BITWIDTH-1:0] BAUD_INIT = 8'd26,
   parameter int                  TIMEOUT   = 15
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic [BITWIDTH-1:0] cfg_baud,
   input  logic                cfg_baud_wr,
   input  logic [BITWIDTH-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   output logic [BITWIDTH-1:0] rx_data,
   output logic                rx_valid,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [1:0]          paddr,
   output logic [BITWIDTH-1:0] pwdata,
   input  logic [BITWIDTH-1:0] prdata,
   input  logic                pready,
   input  logic                tx_rdy_i,
   input  logic                rx_rdy_i,
   output logic                busy,
   output logic                err
);

   apb_state_e          state_q, state_d;
   req_sel_e            sel_q, sel_d;
   logic                pwrite_q, pwrite_d;
   logic [1:0]          paddr_q, paddr_d;
   logic [BITWIDTH-1:0] pwdata_q, pwdata_d;
   logic [BITWIDTH-1:0] baud_val_q, baud_val_d;
   logic                baud_pend_q, baud_pend_d;
   logic                baud_rearm_q, baud_rearm_d;
   logic                rx_armed_q, rx_armed_d;
   logic [BITWIDTH-1:0] rx_data_q, rx_data_d;
   logic                rx_valid_q, rx_valid_d;
   logic                last_rx_q, last_rx_d;

   logic                txq_pop, txq_full, txq_empty;
   logic [BITWIDTH-1:0] txq_head;
   logic                req_baud, req_tx, req_rx;
   logic                grant_baud, xfer_end, baud_done, in_baud;
   logic                tmo_hit;

   apb_uart_txq #(
      .WIDTH (BITWIDTH),
      .DEPTH (TXQ_DEPTH)
   ) u_txq (
      .pclk   (pclk),
      .preset (preset),
      .push   (tx_valid),
      .din    (tx_data),
      .pop    (txq_pop),
      .head   (txq_head),
      .full   (txq_full),
      .empty  (txq_empty)
   );

   assign req_baud = baud_pend_q;
   assign req_tx   = !txq_empty && tx_rdy_i;
   assign req_rx   = rx_rdy_i && rx_armed_q;
   assign xfer_end = (state_q == ST_ACCESS) && (pready || tmo_hit);

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      pwrite_d   = pwrite_q;
      paddr_d    = paddr_q;
      pwdata_d   = pwdata_q;
      last_rx_d  = last_rx_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_armed_d = rx_armed_q | !rx_rdy_i;
      txq_pop    = 1'b0;
      grant_baud = 1'b0;
      psel       = 1'b0;
      penable    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_baud) begin
               grant_baud = 1'b1;
               sel_d      = SEL_BAUD;
               pwrite_d   = 1'b1;
               paddr_d    = ADDR_BAUD;
               pwdata_d   = baud_val_q;
               state_d    = ST_SETUP;
            end else if (req_tx && (!req_rx || last_rx_q)) begin
               sel_d      = SEL_TX;
               pwrite_d   = 1'b1;
               paddr_d    = ADDR_TXD;
               pwdata_d   = txq_head;
               last_rx_d  = 1'b0;
               state_d    = ST_SETUP;
            end else if (req_rx) begin
               sel_d      = SEL_RX;
               pwrite_d   = 1'b0;
               paddr_d    = ADDR_RXD;
               last_rx_d  = 1'b1;
               state_d    = ST_SETUP;
            end
         end
         ST_SETUP: begin
            psel    = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (xfer_end) begin
               state_d = ST_IDLE;
               case (sel_q)
                  SEL_TX: txq_pop = 1'b1;
                  SEL_RX: begin
                     rx_armed_d = 1'b0;
                     if (pready) begin
                        rx_data_d  = prdata;
                        rx_valid_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A rewrite request that lands while a baud write is already committed must survive its completion.
   always_comb begin
      in_baud      = ((state_q != ST_IDLE) && (sel_q == SEL_BAUD)) || grant_baud;
      baud_done    = xfer_end && (sel_q == SEL_BAUD);
      baud_val_d   = cfg_baud_wr ? cfg_baud : baud_val_q;
      baud_pend_d  = baud_pend_q | cfg_baud_wr;
      baud_rearm_d = baud_rearm_q | (cfg_baud_wr && in_baud);
      if (baud_done) begin
         baud_pend_d  = baud_rearm_q | cfg_baud_wr;
         baud_rearm_d = 1'b0;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q      <= ST_IDLE;
         sel_q        <= SEL_NONE;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         baud_val_q   <= BAUD_INIT;
         baud_pend_q  <= 1'b1;
         baud_rearm_q <= 1'b0;
         rx_armed_q   <= 1'b1;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         last_rx_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         baud_val_q   <= baud_val_d;
         baud_pend_q  <= baud_pend_d;
         baud_rearm_q <= baud_rearm_d;
         rx_armed_q   <= rx_armed_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         last_rx_q    <= last_rx_d;
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             err_q, err_d;

   always_comb begin
      tmo_hit   = (state_q == ST_ACCESS) && !pready && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
      tmo_cnt_d = '0;
      if ((state_q == ST_ACCESS) && !pready && !tmo_hit) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      err_d     = err_q | tmo_hit;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign tmo_hit        = 1'b0;
   assign err            = 1'b0;
`endif

   assign pwrite   = pwrite_q;
   assign paddr    = paddr_q;
   assign pwdata   = pwdata_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_ready = !txq_full;
   assign busy     = (state_q != ST_IDLE) || baud_pend_q || !txq_empty;

endmodule

// File: tb/tb_apb_uart_ctrl.sv
// Randomized bench for apb_uart_ctrl: APB slave/UART model, TX/RX scoreboards and a transfer log.
module tb_apb_uart_ctrl;

   localparam logic [7:0] BAUD_INIT = 8'd26;
   localparam int         DEPTH     = 4;

   logic       pclk = 1'b0;
   logic       preset;
   logic [7:0] cfg_baud;
   logic       cfg_baud_wr;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       psel, penable, pwrite;
   logic [1:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata   = 8'h00;
   logic       pready   = 1'b0;
   logic       tx_rdy_i;
   logic       rx_rdy_i = 1'b0;
   logic       busy, err;

   apb_uart_ctrl dut (
      .pclk        (pclk),
      .preset      (preset),
      .cfg_baud    (cfg_baud),
      .cfg_baud_wr (cfg_baud_wr),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .paddr       (paddr),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .tx_rdy_i    (tx_rdy_i),
      .rx_rdy_i    (rx_rdy_i),
      .busy        (busy),
      .err         (err)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [1:0] addr;
      logic       wr;
      logic [7:0] data;
      int         len;
      int         start;
   } xfer_t;

   xfer_t      log_q[$];
   logic [7:0] exp_txq[$];
   logic [7:0] exp_rxq[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int max_wait = 0;
   int rxv_cnt  = 0;
   bit stall    = 0;
   bit rx_auto  = 0;
   bit rx_level = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // APB slave + UART status model; logs each transfer on the negedge before its completing edge.
   int wait_left = 0;
   int cur_len   = 0;
   int cur_start = 0;
   int rx_hold   = 0;
   always @(negedge pclk) begin
      xfer_t x;
      cyc++;
      if (rx_hold > 0) rx_hold--;
      if (preset) begin
         pready  = 1'b0;
         rx_hold = 0;
      end else if (psel && !penable) begin
         cur_len   = 1;
         cur_start = cyc;
         wait_left = $urandom_range(0, max_wait);
         if (!pwrite) prdata = 8'($urandom_range(0, 255));
         pready = 1'b0;
      end else if (psel && penable) begin
         cur_len++;
         pready = !stall && (wait_left == 0);
         if (wait_left > 0) wait_left--;
         if (pready) begin
            x.addr = paddr; x.wr = pwrite; x.data = pwrite ? pwdata : prdata;
            x.len = cur_len; x.start = cur_start;
            log_q.push_back(x);
            if (pwrite && paddr == 2'd2) begin
               if (exp_txq.size() == 0) check("tx_unexpected", 1, 0);
               else check("tx_data", pwdata, exp_txq.pop_front());
            end
            if (!pwrite) begin
               exp_rxq.push_back(prdata);
               if (rx_auto) rx_hold = 2;
            end
         end
      end else begin
         pready = 1'b0;
      end
      rx_rdy_i = rx_auto ? (rx_hold == 0) : rx_level;
   end

   always @(negedge pclk) begin
      if (!preset && rx_valid) begin
         rxv_cnt++;
         if (exp_rxq.size() == 0) check("rx_extra", 1, 0);
         else check("rx_data", rx_data, exp_rxq.pop_front());
      end
   end

   task automatic wait_log(input string tag, input int n, input int budget);
      int k = 0;
      while (log_q.size() < n && k < budget) begin
         @(negedge pclk);
         k++;
      end
      check(tag, (log_q.size() >= n), 1);
   endtask

   task automatic wait_phase(input string tag, input bit want_enable, input int budget);
      int k = 0;
      while (!(psel && penable == want_enable) && k < budget) begin
         @(negedge pclk);
         k++;
      end
      check(tag, (psel && penable == want_enable), 1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((busy || psel) && k < budget) begin
         @(negedge pclk);
         k++;
      end
      check("wait_idle", (busy || psel), 0);
   endtask

   task automatic push_byte(input logic [7:0] d, output bit accepted);
      @(negedge pclk);
      tx_data  = d;
      tx_valid = 1'b1;
      accepted = tx_ready;
      if (accepted) exp_txq.push_back(d);
   endtask

   task automatic end_push();
      @(negedge pclk);
      tx_valid = 1'b0;
   endtask

   initial begin
      bit         acc;
      int         n0, nrx;
      logic [7:0] v1, v2;
      logic [1:0] exp_addr[8];

      preset = 1'b1; cfg_baud = 8'h00; cfg_baud_wr = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; tx_rdy_i = 1'b0;
      repeat (3) @(negedge pclk);

      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_err", err, 0);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 1);

      // Automatic baud write after reset, single-cycle ACCESS.
      @(negedge pclk) preset = 1'b0;
      wait_log("wait_baud_init", 1, 20);
      check("init_addr", log_q[0].addr, 0);
      check("init_wr", log_q[0].wr, 1);
      check("init_data", log_q[0].data, BAUD_INIT);
      check("init_len", log_q[0].len, 2);
      repeat (2) @(negedge pclk);
      check("init_busy_clear", busy, 0);

      // TX with UART ready: three bytes written in order, queue never fills.
      max_wait = 2;
      tx_rdy_i = 1'b1;
      push_byte(8'h41, acc); check("push_41", acc, 1);
      push_byte(8'h42, acc); check("push_42", acc, 1);
      push_byte(8'h43, acc); check("push_43", acc, 1);
      end_push();
      wait_log("wait_tx3", 4, 60);
      for (int i = 1; i < 4; i++) check("tx3_addr", log_q[i].addr, 2);
      wait_idle(40);

      // Queue fill with UART not ready: 4 accepted, 5th dropped, then back-to-back drain.
      max_wait = 0;
      tx_rdy_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push_byte(8'($urandom_range(0, 255)), acc);
         check("fill_accept", acc, (i < DEPTH));
      end
      end_push();
      check("full_tx_ready", tx_ready, 0);
      n0 = log_q.size();
      tx_rdy_i = 1'b1;
      wait_log("wait_drain", n0 + 4, 60);
      for (int i = 1; i < 4; i++) check("drain_gap", log_q[n0+i].start - log_q[n0+i-1].start, 3);
      repeat (10) @(negedge pclk);
      check("drain_count", log_q.size(), n0 + 4);
      check("drain_tx_ready", tx_ready, 1);
      check("drain_model_empty", exp_txq.size(), 0);
      tx_rdy_i = 1'b0;

      // RX with RX_RDY held: exactly one read until RX_RDY drops and rises again.
      max_wait = 3;
      n0 = log_q.size();
      nrx = rxv_cnt;
      rx_level = 1'b1;
      wait_log("wait_rx1", n0 + 1, 40);
      repeat (20) @(negedge pclk);
      check("rx1_count", log_q.size(), n0 + 1);
      check("rx1_addr", log_q[n0].addr, 3);
      check("rx1_wr", log_q[n0].wr, 0);
      check("rx1_pulses", rxv_cnt, nrx + 1);
      check("rx1_hold", rx_data, log_q[n0].data);
      rx_level = 1'b0;
      repeat (2) @(negedge pclk);
      rx_level = 1'b1;
      wait_log("wait_rx_rearm", n0 + 2, 40);
      check("rx_rearm_addr", log_q[n0+1].addr, 3);
      rx_level = 1'b0;
      wait_idle(40);

      // Reset during a stalled baud write aborts at once and restores BAUD_INIT.
      stall = 1'b1;
      @(negedge pclk); cfg_baud = 8'h77; cfg_baud_wr = 1'b1;
      @(negedge pclk); cfg_baud_wr = 1'b0;
      wait_phase("wait_stalled_access", 1'b1, 20);
      preset = 1'b1;
      #1;
      check("midrst_psel", psel, 0);
      check("midrst_penable", penable, 0);
      exp_txq.delete();
      stall = 1'b0;
      repeat (2) @(negedge pclk);
      n0 = log_q.size();
      preset = 1'b0;
      wait_log("wait_rst_baud", n0 + 1, 20);
      check("rst_baud_data", log_q[n0].data, BAUD_INIT);

      // TX/RX contention: round robin from reset (RX first), baud rewrite preempts mid-stream.
      max_wait = 2;
      for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)), acc);
      end_push();
      n0 = log_q.size();
      tx_rdy_i = 1'b1;
      rx_auto  = 1'b1;
      wait_log("wait_rr2", n0 + 2, 40);
      wait_phase("wait_rr_setup", 1'b0, 20);
      v1 = 8'($urandom_range(0, 127));
      v2 = v1 + 8'd128;
      cfg_baud = v1; cfg_baud_wr = 1'b1;
      @(negedge pclk); cfg_baud = v2;
      @(negedge pclk); cfg_baud_wr = 1'b0;
      wait_log("wait_rr8", n0 + 8, 120);
      exp_addr = '{2'd3, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
      for (int i = 0; i < 8; i++) check("rr_order", log_q[n0+i].addr, exp_addr[i]);
      check("rebaud_data", log_q[n0+3].data, v2);
      rx_auto  = 1'b0;
      tx_rdy_i = 1'b0;
      wait_idle(60);
      repeat (4) @(negedge pclk);

`ifdef APB_TIMEOUT_EN
      // Stalled ACCESS aborts after TIMEOUT cycles, drops the byte, sets sticky err.
      begin
         int acc_cycles = 0;
         stall = 1'b1;
         tx_rdy_i = 1'b1;
         push_byte(8'($urandom_range(0, 255)), acc);
         end_push();
         n0 = log_q.size();
         wait_phase("wait_tmo_access", 1'b1, 20);
         while (psel && penable && acc_cycles < 40) begin
            acc_cycles++;
            @(negedge pclk);
         end
         check("tmo_access_cycles", acc_cycles, 15);
         check("tmo_err", err, 1);
         check("tmo_psel", psel, 0);
         if (exp_txq.size() > 0) void'(exp_txq.pop_front());
         stall = 1'b0;
         push_byte(8'($urandom_range(0, 255)), acc);
         end_push();
         wait_log("wait_after_tmo", n0 + 1, 40);
         wait_idle(40);
         check("tmo_no_extra", log_q.size(), n0 + 1);
         check("tmo_err_sticky", err, 1);
         tx_rdy_i = 1'b0;
      end
`else
      check("err_tied_low", err, 0);
`endif

      nrx = 0;
      foreach (log_q[i]) if (!log_q[i].wr) nrx++;
      check("rx_pulse_total", rxv_cnt, nrx);
      check("rx_model_empty", exp_rxq.size(), 0);
      check("tx_model_empty", exp_txq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, got 1, expected 0");
      $fatal(1, "global timeout");
   end

endmodule
